mix_columns_seq: RTL

Column-serial forward AES MixColumns engine for the encrypt datapath. It is the encrypt-direction counterpart of the existing InvMixColumns GF(2^8) multiplier units, using the ×02/×03 coefficients.
- Accepts a 128-bit state over a valid/ready handshake.
- Transforms one 32-bit column per clock over 4 cycles.
- Presents the result on a valid/ready output with backpressure.
- Sits between the ShiftRows and AddRoundKey stages of the round pipeline.

---
 rtl/mix_columns_seq_if.sv | 27 ++
 rtl/mix_columns_seq.sv | 86 ++++++++
 2 files changed

// File: rtl/mix_columns_seq_if.sv
// mix_columns_seq_if: valid/ready in/out bundle for the MixColumns engine.
// MIX_INV_EN adds the per-block inverse-select inv_i.
interface mix_columns_seq_if;
  logic           in_valid;
  logic           in_ready;
  logic [0:127]   state_i;
  logic           out_valid;
  logic           out_ready;
  logic [0:127]   state_o;
`ifdef MIX_INV_EN
  logic           inv_i;
`endif
  modport master (
`ifdef MIX_INV_EN
    output inv_i,
`endif
    output in_valid, state_i, out_ready,
    input  in_ready, out_valid, state_o
  );
  modport slave (
`ifdef MIX_INV_EN
    input  inv_i,
`endif
    input  in_valid, state_i, out_ready,
    output in_ready, out_valid, state_o
  );
endinterface

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: column-serial AES MixColumns, one column per clock over 4 cycles.
// MIX_INV_EN adds inv_i selecting InvMixColumns, latched at accept.
module mix_columns_seq (
  input logic                 clk,
  input logic                 rst_n,
  mix_columns_seq_if.slave    io
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t       st, st_nx;
  logic [1:0]   cnt;
  logic [0:127] work;
  logic [31:0]  col, col_nx;
`ifdef MIX_INV_EN
  logic         inv;
`endif
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] fmix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
`ifdef MIX_INV_EN
  function automatic logic [31:0] imix(input logic [31:0] c);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a = c[31-8*i -: 8];
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif
  always_comb begin
    col = work[{cnt, 5'b0} +: 32];
`ifdef MIX_INV_EN
    col_nx = inv ? imix(col) : fmix(col);
`else
    col_nx = fmix(col);
`endif
    st_nx = st == IDLE ? (io.in_valid ? BUSY : IDLE) :
            st == BUSY ? (cnt == 2'd3 ? DONE : BUSY) :
                         (io.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      cnt  <= '0;
      work <= '0;
`ifdef MIX_INV_EN
      inv  <= 1'b0;
`endif
    end else begin
      st <= st_nx;
      if (st == IDLE && io.in_valid) begin
        work <= io.state_i;
        cnt  <= '0;
`ifdef MIX_INV_EN
        inv  <= io.inv_i;
`endif
      end else if (st == BUSY) begin
        work[{cnt, 5'b0} +: 32] <= col_nx;
        cnt <= cnt + 2'd1;
      end
    end
  end
  assign io.in_ready  = st == IDLE;
  assign io.out_valid = st == DONE;
  assign io.state_o   = work;
endmodule
